// File: rtl/snake_pkg.sv
// Shared snake-game definitions: grid extents, fruit-table word layout and
// the fruit spawner state encoding.
package snake_pkg;

   localparam int GRID_ROWS = 15;
   localparam int GRID_COLS = 21;

   localparam int FRUIT_DEPTH  = 31;
   localparam int FRUIT_ADDR_W = 5;

   localparam int ROW_W   = 4;
   localparam int COL_W   = 5;
   localparam int POS_W   = ROW_W + COL_W + 1;
   localparam int POS_LSB = 4;
   localparam int POS_MSB = POS_LSB + POS_W - 1;

   // Top bit is reserved and must read as zero for a usable entry.
   typedef struct packed {
      logic             rsvd;
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } fruit_pos_t;

   typedef enum logic [2:0] {
      SP_IDLE,
      SP_FETCH,
      SP_CHECK,
      SP_QUERY,
      SP_FULL
   } spawn_state_e;

endpackage

// File: rtl/fruit_spawner.sv
// Walks the fruit position table, rejecting off-grid or snake-covered cells,
// and presents the accepted fruit to the display and score path.
module fruit_spawner
   import snake_pkg::*;
#(
   parameter int TABLE_DEPTH = FRUIT_DEPTH,
   parameter int ADDR_W      = FRUIT_ADDR_W,
   parameter int MAX_ROW     = GRID_ROWS - 1,
   parameter int MAX_COL     = GRID_COLS - 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       fruit_next,
   output logic [ADDR_W-1:0] fruit_addr,
   input  logic              eat,
   output logic              occ_req,
   output logic [ROW_W-1:0]  occ_row,
   output logic [COL_W-1:0]  occ_col,
   input  logic              occ_ack,
   input  logic              occ_hit,
   output logic              fruit_valid,
   output logic [ROW_W-1:0]  fruit_row,
   output logic [COL_W-1:0]  fruit_col,
   output logic [7:0]        spawn_count,
   output logic              board_full
);

   localparam int TRY_W = $clog2(TABLE_DEPTH);

   spawn_state_e      state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   fruit_pos_t        cand_q, cand_d;
   logic [TRY_W-1:0]  tries_q, tries_d;
   logic              req_q, req_d;
   logic [ROW_W-1:0]  orow_q, orow_d;
   logic [COL_W-1:0]  ocol_q, ocol_d;
   logic              fv_q, fv_d;
   logic [ROW_W-1:0]  frow_q, frow_d;
   logic [COL_W-1:0]  fcol_q, fcol_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              full_q, full_d;
   logic              reject;
   logic              unused_bits;

   function automatic logic pos_ok(input fruit_pos_t p);
      return !p.rsvd
         && (int'(p.row) <= MAX_ROW)
         && (int'(p.col) <= MAX_COL);
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(
      input logic [ADDR_W-1:0] a
   );
      return (a == ADDR_W'(TABLE_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
   endfunction

   assign unused_bits = ^{fruit_next[31:POS_MSB+1],
                          fruit_next[POS_LSB-1:0]};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cand_d  = cand_q;
      tries_d = tries_q;
      req_d   = req_q;
      orow_d  = orow_q;
      ocol_d  = ocol_q;
      fv_d    = fv_q;
      frow_d  = frow_q;
      fcol_d  = fcol_q;
      cnt_d   = cnt_q;
      full_d  = full_q;
      reject  = 1'b0;
      unique case (state_q)
         SP_IDLE: begin
            if (eat) begin
               fv_d    = 1'b0;
               addr_d  = next_addr(addr_q);
               tries_d = '0;
               state_d = SP_FETCH;
            end
         end
         SP_FETCH: begin
            cand_d  = fruit_pos_t'(fruit_next[POS_MSB:POS_LSB]);
            state_d = SP_CHECK;
         end
         SP_CHECK: begin
            if (pos_ok(cand_q)) begin
               req_d   = 1'b1;
               orow_d  = cand_q.row;
               ocol_d  = cand_q.col;
               state_d = SP_QUERY;
            end else begin
               reject = 1'b1;
            end
         end
         SP_QUERY: begin
            if (occ_ack) begin
               req_d = 1'b0;
               if (occ_hit) begin
                  reject = 1'b1;
               end else begin
                  frow_d  = cand_q.row;
                  fcol_d  = cand_q.col;
                  fv_d    = 1'b1;
                  cnt_d   = cnt_q + 8'd1;
                  state_d = SP_IDLE;
               end
            end
         end
         SP_FULL: begin
            fv_d  = 1'b0;
            req_d = 1'b0;
         end
         default: state_d = SP_FETCH;
      endcase
      // A full lap of rejects means no free cell is reachable.
      if (reject) begin
         if (tries_q == TRY_W'(TABLE_DEPTH - 1)) begin
            full_d  = 1'b1;
            state_d = SP_FULL;
         end else begin
            tries_d = tries_q + TRY_W'(1);
            addr_d  = next_addr(addr_q);
            state_d = SP_FETCH;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SP_FETCH;
         addr_q  <= '0;
         cand_q  <= '0;
         tries_q <= '0;
         req_q   <= 1'b0;
         orow_q  <= '0;
         ocol_q  <= '0;
         fv_q    <= 1'b0;
         frow_q  <= '0;
         fcol_q  <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cand_q  <= cand_d;
         tries_q <= tries_d;
         req_q   <= req_d;
         orow_q  <= orow_d;
         ocol_q  <= ocol_d;
         fv_q    <= fv_d;
         frow_q  <= frow_d;
         fcol_q  <= fcol_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
      end
   end

   assign fruit_addr  = addr_q;
   assign occ_req     = req_q;
   assign occ_row     = orow_q;
   assign occ_col     = ocol_q;
   assign fruit_valid = fv_q;
   assign fruit_row   = frow_q;
   assign fruit_col   = fcol_q;
   assign spawn_count = cnt_q;
   assign board_full  = full_q;

endmodule

// File: tb/tb_fruit_spawner.sv
// Scoreboard bench for fruit_spawner: table and occupancy models feed the DUT,
// expected placements are queued at stimulus time and matched on fruit_valid.
module tb_fruit_spawner;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fruit_next;
   logic [4:0]  fruit_addr;
   logic        eat;
   logic        occ_req;
   logic [3:0]  occ_row;
   logic [4:0]  occ_col;
   logic        occ_ack;
   logic        occ_hit;
   logic        fruit_valid;
   logic [3:0]  fruit_row;
   logic [4:0]  fruit_col;
   logic [7:0]  spawn_count;
   logic        board_full;

   typedef struct {
      logic [4:0] addr;
      logic [3:0] row;
      logic [4:0] col;
      logic [7:0] cnt;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] tbl [0:31];
   logic        occ_map [0:15][0:31];
   logic        occ_all;
   int          ack_delay;
   int          wait_cnt = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [4:0]  m_addr;
   logic [7:0]  m_cnt;
   bit          m_full;
   logic        prev_fv = 1'b0;
   logic        prev_req = 1'b0;
   logic [3:0]  prev_row = '0;
   logic [4:0]  prev_col = '0;

   always #5 clk = ~clk;

   fruit_spawner dut (
      .clk         (clk),
      .rst         (rst),
      .fruit_next  (fruit_next),
      .fruit_addr  (fruit_addr),
      .eat         (eat),
      .occ_req     (occ_req),
      .occ_row     (occ_row),
      .occ_col     (occ_col),
      .occ_ack     (occ_ack),
      .occ_hit     (occ_hit),
      .fruit_valid (fruit_valid),
      .fruit_row   (fruit_row),
      .fruit_col   (fruit_col),
      .spawn_count (spawn_count),
      .board_full  (board_full)
   );

   assign fruit_next = tbl[fruit_addr];
   assign occ_hit    = occ_all | occ_map[occ_row][occ_col];
   assign occ_ack    = occ_req && (wait_cnt >= ack_delay);

   always @(posedge clk) begin
      if (!occ_req) wait_cnt <= 0;
      else          wait_cnt <= wait_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int r, input int c);
      return {18'h25a3c, 1'b0, 4'(r), 5'(c), 4'ha};
   endfunction

   function automatic logic [4:0] nxt(input logic [4:0] a);
      return (a == 5'd30) ? 5'd0 : a + 5'd1;
   endfunction

   // Reference scan: first in-bounds free cell starting at `start`.
   function automatic void model_scan(
      input  logic [4:0] start,
      output bit         found,
      output logic [4:0] a_out,
      output logic [3:0] r,
      output logic [4:0] c,
      output int         lat
   );
      logic [4:0]  a;
      logic [31:0] w;
      logic [9:0]  p;
      bit          inb;
      a     = start;
      lat   = 4 + ack_delay;
      found = 0;
      a_out = start;
      r     = '0;
      c     = '0;
      for (int i = 0; i < 31; i++) begin
         w     = tbl[a];
         p     = w[13:4];
         inb   = !p[9] && (p[8:5] <= 4'd14) && (p[4:0] <= 5'd20);
         a_out = a;
         if (inb && !(occ_all || occ_map[p[8:5]][p[4:0]])) begin
            found = 1;
            r     = p[8:5];
            c     = p[4:0];
            return;
         end
         lat += inb ? 3 + ack_delay : 2;
         a    = nxt(a);
      end
   endfunction

   always @(negedge clk) begin
      if (!rst && fruit_valid && !prev_fv) begin
         if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
         end else begin
            chk("fruit_addr", 32'(fruit_addr), 32'(sb[0].addr));
            chk("fruit_row", 32'(fruit_row), 32'(sb[0].row));
            chk("fruit_col", 32'(fruit_col), 32'(sb[0].col));
            chk("spawn_cnt", 32'(spawn_count), 32'(sb[0].cnt));
            void'(sb.pop_front());
         end
      end
      if (occ_req && !prev_req)
         chk("occ_range", 32'(occ_row <= 4'd14 && occ_col <= 5'd20), 32'd1);
      if (occ_req && prev_req) begin
         chk("occ_row_hold", 32'(occ_row), 32'(prev_row));
         chk("occ_col_hold", 32'(occ_col), 32'(prev_col));
      end
      prev_fv  <= fruit_valid;
      prev_req <= occ_req;
      prev_row <= occ_row;
      prev_col <= occ_col;
   end

   task automatic do_eat();
      bit         f;
      logic [4:0] a, r, c5;
      logic [3:0] r4;
      int         lat, n;
      f = 0;
      a = m_addr;
      lat = 0;
      if (!m_full) begin
         model_scan(nxt(m_addr), f, a, r4, c5, lat);
         if (f) begin
            m_cnt = m_cnt + 8'd1;
            sb.push_back('{a, r4, c5, m_cnt});
         end
      end
      r = '0;
      @(posedge clk); #1 eat = 1'b1;
      @(posedge clk); #1 eat = 1'b0;
      if (m_full) begin
         repeat (4) @(posedge clk);
         #1;
         chk("full_valid_hold", 32'(fruit_valid), 32'd0);
         chk("full_cnt_hold", 32'(spawn_count), 32'(m_cnt));
         chk("full_req_hold", 32'(occ_req), 32'd0);
         chk("full_addr_hold", 32'(fruit_addr), 32'(m_addr));
         return;
      end
      chk("eat_drop", 32'(fruit_valid), 32'd0);
      chk("eat_addr", 32'(fruit_addr), 32'(nxt(m_addr)));
      n = 1;
      if (f) begin
         while (!fruit_valid && n < 400) begin
            @(posedge clk); #1; n++;
         end
         chk("latency", n, lat);
      end else begin
         while (!board_full && n < 400) begin
            @(posedge clk); #1; n++;
         end
         chk("board_full", 32'(board_full), 32'd1);
         chk("full_req", 32'(occ_req), 32'd0);
         chk("full_valid", 32'(fruit_valid), 32'd0);
         chk("full_addr", 32'(fruit_addr), 32'(a));
         m_full = 1;
      end
      m_addr = a;
   endtask

   task automatic do_reset(input bit mid);
      bit         f;
      logic [4:0] a, c5;
      logic [3:0] r4;
      int         lat, n;
      if (mid) begin
         @(posedge clk); #1 eat = 1'b1;
         @(posedge clk); #1 eat = 1'b0;
         n = 0;
         while (!occ_req && n < 50) begin
            @(posedge clk); #1; n++;
         end
         chk("mid_query_req", 32'(occ_req), 32'd1);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      ack_delay = 0;
      chk("rst_addr", 32'(fruit_addr), 32'd0);
      chk("rst_req", 32'(occ_req), 32'd0);
      chk("rst_orow", 32'(occ_row), 32'd0);
      chk("rst_ocol", 32'(occ_col), 32'd0);
      chk("rst_valid", 32'(fruit_valid), 32'd0);
      chk("rst_frow", 32'(fruit_row), 32'd0);
      chk("rst_fcol", 32'(fruit_col), 32'd0);
      chk("rst_cnt", 32'(spawn_count), 32'd0);
      chk("rst_full", 32'(board_full), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      sb.delete();
      m_full = 0;
      m_cnt  = '0;
      model_scan(5'd0, f, a, r4, c5, lat);
      if (f) begin
         m_cnt = 8'd1;
         sb.push_back('{a, r4, c5, m_cnt});
      end
      m_addr = a;
      n = 0;
      while (!fruit_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("rst_spawn", 32'(fruit_valid), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      eat       = 1'b0;
      ack_delay = 0;
      occ_all   = 1'b0;
      m_addr    = '0;
      m_cnt     = '0;
      m_full    = 0;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 32; j++)
            occ_map[i][j] = 1'b0;
      for (int i = 0; i < 32; i++) tbl[i] = mk(15, i % 21);
      tbl[0] = mk(12, 17);
      tbl[1] = mk(12, 4);
      tbl[2] = mk(10, 6);
      tbl[3] = mk(1, 16);
      tbl[4] = mk(15, 3);
      tbl[5] = mk(2, 21);
      tbl[6] = mk(1, 1) | 32'h0000_2000;
      tbl[7] = mk(14, 20);
      tbl[30] = mk(5, 5);

      do_reset(0);
      do_eat();
      occ_map[10][6] = 1'b1;
      do_eat();
      do_eat();
      do_eat();
      ack_delay = 5;
      do_eat();
      ack_delay = 0;
      occ_all   = 1'b1;
      do_eat();
      do_eat();
      occ_all = 1'b0;
      do_reset(0);
      ack_delay = 20;
      do_reset(1);
      repeat (5) @(posedge clk);
      #1;
      chk("sb_drain", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
